serv_ifetch: RTL and testbench
==============================

// Module: serv_ifetch
// PURPOSE
//  Instruction-fetch stage directly upstream of the decoder. Deserialises the bit-serial
//  next-PC from the control unit and issues a Wishbone-classic read on the instruction bus.
//  Holds the returned word until the decoder is idle, then presents it with a one-cycle enable.
//  The decoder latches opcode, register addresses, funct3 and immediate on that enable.
// PARAMETERS
//  RESET_PC  32'h0000_0000  address of the first fetch after reset
// PORTS
//  clk          in   1   clock
//  i_rst        in   1   reset, synchronous, active-high
//  i_pc_en      in   1   serial next-PC bit valid (one bit per cycle, LSB first)
//  i_pc         in   1   serial next-PC data bit
//  o_ibus_adr   out  32  instruction bus address
//  o_ibus_cyc   out  1   instruction bus cycle/strobe
//  i_ibus_rdt   in   32  instruction bus read data
//  i_ibus_ack   in   1   instruction bus acknowledge
//  i_dec_ready  in   1   decoder idle, can accept an instruction this cycle
//  o_dec_rdt    out  32  instruction word to decoder
//  o_dec_en     out  1   one-cycle strobe: o_dec_rdt valid, decoder must latch
//  o_busy       out  1   fetch in flight or instruction pending (state != WAITPC)
// BEHAVIOUR
//  Reset values:
//   - state=REQ, adr=RESET_PC, bitcnt=0, o_ibus_cyc=0, o_dec_en=0, o_dec_rdt=0.
//   - o_ibus_cyc rises the first cycle after i_rst deasserts.
//  States:
//   - REQ: o_ibus_cyc=1, adr stable. On i_ibus_ack: ir<=i_ibus_rdt, cyc low next cycle, ->VALID.
//   - VALID: o_dec_en = (state==VALID) & i_dec_ready (combinational), o_dec_rdt=ir.
//     Same edge ->WAITPC. i_dec_ready low holds VALID with ir unchanged, indefinitely.
//   - WAITPC: each i_pc_en cycle: adr<={i_pc,adr[31:1]}, bitcnt++ (5-bit).
//     Cycle with i_pc_en & bitcnt==31 completes the PC; bitcnt wraps to 0, ->REQ.
//  Latency:
//   - ack -> o_dec_en is 1 cycle when i_dec_ready is high.
//   - Last PC bit -> o_ibus_cyc is 1 cycle.
//   - Zero-wait ack (ack in the first REQ cycle) is legal.
//  Protocol rules:
//   - i_pc_en in REQ or VALID is ignored (adr must stay stable while cyc is high).
//     Simulation assertion flags it.
//   - i_ibus_ack outside REQ is ignored.
//   - adr[1:0] is passed through unchecked; misalignment is handled downstream.
//  Boundary conditions:
//   - i_rst with i_ibus_ack in the same cycle: reset wins, word dropped, refetch from RESET_PC.
//   - i_rst mid-shift clears bitcnt; partial PC is discarded.
//   - i_rst in VALID: o_dec_en is forced 0 that cycle.
//   - o_ibus_cyc never stays high for more than 1 cycle after the ack.
// STRUCTURE
//  - serv_params.vh gains FETCH_REQ=2'd0, FETCH_VALID=2'd1, FETCH_WAITPC=2'd2
//    (2-bit state encoding, default branch ->REQ).
//  - Sub-module serv_pc_deser: 32-bit LSB-first shift register plus 5-bit bit counter.
//    Outputs the parallel value and a done pulse. The parent owns the FSM and the IR.
// TESTING
//  1. RESET_PC=32'h80, release i_rst, ack after 3 waits with 32'h00500093, i_dec_ready=1
//     -> adr=0x80, cyc high 4 cycles.
//     -> o_dec_en 1-cycle pulse the cycle after ack, o_dec_rdt=32'h00500093.
//  2. Shift 32'h00000104 LSB first on i_pc/i_pc_en
//     -> cyc rises the cycle after the 32nd bit, o_ibus_adr=32'h00000104.
//  3. Ack with i_dec_ready=0 for 5 cycles, then 1
//     -> o_dec_en stays 0, then a single pulse, ir stable throughout.
//  4. i_rst asserted in the same cycle as ack while fetching 0x200
//     -> no o_dec_en, next cycle after reset: cyc=1, adr=RESET_PC.
//  5. Zero-wait ack, i_pc_en toggled during REQ
//     -> adr unchanged, assertion fires, instruction delivered correctly.
//  6. Gaps in i_pc_en (bits spread over 50 cycles)
//     -> adr assembled correctly, fetch starts only after the 32nd valid bit.

Source files
------------

// File: rtl/serv_ifetch_pkg.sv
// Shared types for the instruction-fetch stage: FSM state encoding and datapath widths.
package serv_ifetch_pkg;

    localparam int PC_W     = 32;
    localparam int BITCNT_W = 5;

    typedef enum logic [1:0] {
        FETCH_REQ    = 2'd0,
        FETCH_VALID  = 2'd1,
        FETCH_WAITPC = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/serv_ifetch_pc_deser.sv
// LSB-first deserialiser for the bit-serial next PC; done pulses with the 32nd valid bit.
module serv_ifetch_pc_deser
    import serv_ifetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic            i_bit,
    output logic [PC_W-1:0] o_pc,
    output logic            o_done
);

    logic [PC_W-1:0]     shreg;
    logic [BITCNT_W-1:0] bitcnt;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            shreg  <= RESET_PC;
            bitcnt <= '0;
        end else if (i_en) begin
            shreg  <= {i_bit, shreg[PC_W-1:1]};
            bitcnt <= bitcnt + 1'b1;
        end
    end

    // Counter wraps to zero naturally on the completing bit.
    assign o_done = i_en & (bitcnt == '1);
    assign o_pc   = shreg;

endmodule

// File: rtl/serv_ifetch.sv
// Instruction fetch: assembles the serial PC, runs a Wishbone-classic read, hands the word to the decoder.
module serv_ifetch
    import serv_ifetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            i_rst,
    input  logic            i_pc_en,
    input  logic            i_pc,
    output logic [PC_W-1:0] o_ibus_adr,
    output logic            o_ibus_cyc,
    input  logic [PC_W-1:0] i_ibus_rdt,
    input  logic            i_ibus_ack,
    input  logic            i_dec_ready,
    output logic [PC_W-1:0] o_dec_rdt,
    output logic            o_dec_en,
    output logic            o_busy
);

    fetch_state_e    state;
    fetch_state_e    state_nxt;
    logic [PC_W-1:0] ir;
    logic            shift_en;
    logic            pc_done;

    // Address must stay frozen while a bus cycle is open, so shifting is gated by state.
    assign shift_en = i_pc_en & (state == FETCH_WAITPC);

    serv_ifetch_pc_deser #(
        .RESET_PC (RESET_PC)
    ) u_pc_deser (
        .clk    (clk),
        .i_rst  (i_rst),
        .i_en   (shift_en),
        .i_bit  (i_pc),
        .o_pc   (o_ibus_adr),
        .o_done (pc_done)
    );

    always_ff @(posedge clk) begin
        if (i_rst)
            state <= FETCH_REQ;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH_REQ:    if (i_ibus_ack)  state_nxt = FETCH_VALID;
            FETCH_VALID:  if (i_dec_ready) state_nxt = FETCH_WAITPC;
            FETCH_WAITPC: if (pc_done)     state_nxt = FETCH_REQ;
            default:                       state_nxt = FETCH_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst)
            ir <= '0;
        else if ((state == FETCH_REQ) && i_ibus_ack)
            ir <= i_ibus_rdt;
    end

    // Reset gates the strobes so nothing leaks out during the reset cycle itself.
    always_comb begin
        o_ibus_cyc = (state == FETCH_REQ) & ~i_rst;
        o_dec_en   = (state == FETCH_VALID) & i_dec_ready & ~i_rst;
        o_busy     = (state != FETCH_WAITPC);
        o_dec_rdt  = ir;
    end

    pc_en_outside_waitpc: assert property (@(posedge clk) disable iff (i_rst)
        !(i_pc_en && (state != FETCH_WAITPC)))
        else $warning("i_pc_en outside WAITPC ignored");

endmodule

// File: tb/tb_serv_ifetch.sv
// Self-checking bench for serv_ifetch: vector table, hand-written corner sequences, random fetches.
module tb_serv_ifetch;

    localparam logic [31:0] RST_PC = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_pc_en = 1'b0;
    logic        i_pc = 1'b0;
    logic [31:0] o_ibus_adr;
    logic        o_ibus_cyc;
    logic [31:0] i_ibus_rdt = '0;
    logic        i_ibus_ack = 1'b0;
    logic        i_dec_ready = 1'b0;
    logic [31:0] o_dec_rdt;
    logic        o_dec_en;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serv_ifetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_pc_en     (i_pc_en),
        .i_pc        (i_pc),
        .o_ibus_adr  (o_ibus_adr),
        .o_ibus_cyc  (o_ibus_cyc),
        .i_ibus_rdt  (i_ibus_rdt),
        .i_ibus_ack  (i_ibus_ack),
        .i_dec_ready (i_dec_ready),
        .o_dec_rdt   (o_dec_rdt),
        .o_dec_en    (o_dec_en),
        .o_busy      (o_busy)
    );

    typedef struct {
        logic        ack;
        logic [31:0] rdt;
        logic        ready;
        logic        exp_cyc;
        logic        exp_en;
        logic        exp_busy;
        logic [31:0] exp_adr;
        logic [31:0] exp_rdt;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Sends a PC bit by bit with optional idle gaps; the expected address is rebuilt arithmetically.
    task automatic shift_pc(input logic [31:0] value, input int max_gap, output logic [31:0] model_pc);
        model_pc = '0;
        for (int i = 0; i < 32; i++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin
                i_pc_en = 1'b0; i_pc = 1'($urandom);
                #1; check("cyc_gap", {31'b0, o_ibus_cyc}, 32'd0);
                step();
            end
            i_pc_en = 1'b1; i_pc = value[i];
            model_pc = model_pc + ((value[i] ? 32'd1 : 32'd0) << i);
            #1;
            check("cyc_shift", {31'b0, o_ibus_cyc}, 32'd0);
            check("busy_shift", {31'b0, o_busy}, 32'd0);
            step();
        end
        i_pc_en = 1'b0;
    endtask

    // Starts in REQ; ends one cycle into WAITPC.
    task automatic do_fetch(input int waits, input logic [31:0] adr, input logic [31:0] word, input int hold);
        for (int i = 0; i < waits; i++) begin
            i_ibus_ack = 1'b0; i_dec_ready = 1'($urandom);
            #1;
            check("cyc_wait", {31'b0, o_ibus_cyc}, 32'd1);
            check("adr_wait", o_ibus_adr, adr);
            check("en_wait", {31'b0, o_dec_en}, 32'd0);
            step();
        end
        i_ibus_ack = 1'b1; i_ibus_rdt = word;
        #1;
        check("cyc_ack", {31'b0, o_ibus_cyc}, 32'd1);
        check("adr_ack", o_ibus_adr, adr);
        step();
        i_ibus_ack = 1'($urandom); i_ibus_rdt = $urandom;
        for (int i = 0; i < hold; i++) begin
            i_dec_ready = 1'b0;
            #1;
            check("en_hold", {31'b0, o_dec_en}, 32'd0);
            check("rdt_hold", o_dec_rdt, word);
            check("cyc_hold", {31'b0, o_ibus_cyc}, 32'd0);
            step();
        end
        i_dec_ready = 1'b1;
        #1;
        check("en_pulse", {31'b0, o_dec_en}, 32'd1);
        check("rdt_pulse", o_dec_rdt, word);
        check("cyc_after_ack", {31'b0, o_ibus_cyc}, 32'd0);
        step();
        i_ibus_ack = 1'b0;
        #1;
        check("en_after", {31'b0, o_dec_en}, 32'd0);
        check("busy_waitpc", {31'b0, o_busy}, 32'd0);
        step();
        i_dec_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] m;
        logic [31:0] w;

        vecs[0] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, RST_PC, 32'h0};
        vecs[1] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, RST_PC, 32'h0};
        vecs[2] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b1, RST_PC, 32'h0};
        vecs[3] = '{1'b1, 32'h00500093, 1'b1, 1'b1, 1'b0, 1'b1, RST_PC, 32'h0};
        vecs[4] = '{1'b0, 32'hdeadbeef, 1'b1, 1'b0, 1'b1, 1'b1, RST_PC, 32'h00500093};
        vecs[5] = '{1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, RST_PC, 32'h00500093};

        // Reset state
        i_rst = 1'b1;
        step(); step();
        check("rst_cyc", {31'b0, o_ibus_cyc}, 32'd0);
        check("rst_en", {31'b0, o_dec_en}, 32'd0);
        check("rst_rdt", o_dec_rdt, 32'd0);
        check("rst_adr", o_ibus_adr, RST_PC);
        check("rst_busy", {31'b0, o_busy}, 32'd1);
        i_rst = 1'b0;

        // First fetch from RESET_PC, three wait states
        for (int i = 0; i < 6; i++) begin
            i_ibus_ack = vecs[i].ack; i_ibus_rdt = vecs[i].rdt; i_dec_ready = vecs[i].ready;
            #1;
            check("vec_cyc", {31'b0, o_ibus_cyc}, {31'b0, vecs[i].exp_cyc});
            check("vec_en", {31'b0, o_dec_en}, {31'b0, vecs[i].exp_en});
            check("vec_busy", {31'b0, o_busy}, {31'b0, vecs[i].exp_busy});
            check("vec_adr", o_ibus_adr, vecs[i].exp_adr);
            check("vec_rdt", o_dec_rdt, vecs[i].exp_rdt);
            step();
        end
        i_ibus_ack = 1'b0; i_dec_ready = 1'b0;

        // Back-to-back PC then fetch at 0x104
        shift_pc(32'h0000_0104, 0, m);
        do_fetch(2, m, 32'h1234_5678, 0);

        // Decoder stalled for five cycles
        pc = $urandom;
        shift_pc(pc, 0, m);
        do_fetch(1, m, 32'hcafe_f00d, 5);

        // Reset coincident with ack while fetching 0x200
        shift_pc(32'h0000_0200, 0, m);
        i_ibus_ack = 1'b0;
        #1; check("adr_0x200", o_ibus_adr, 32'h0000_0200);
        step();
        i_ibus_ack = 1'b1; i_ibus_rdt = 32'h0bad_0bad; i_dec_ready = 1'b1; i_rst = 1'b1;
        #1; check("rstack_en", {31'b0, o_dec_en}, 32'd0);
        step();
        i_rst = 1'b0; i_ibus_ack = 1'b0;
        #1;
        check("rstack_cyc", {31'b0, o_ibus_cyc}, 32'd1);
        check("rstack_adr", o_ibus_adr, RST_PC);
        check("rstack_en2", {31'b0, o_dec_en}, 32'd0);
        check("rstack_rdt", o_dec_rdt, 32'd0);
        step();
        do_fetch(1, RST_PC, 32'h0000_0013, 0);

        // Reset partway through shifting a PC
        for (int i = 0; i < 10; i++) begin
            i_pc_en = 1'b1; i_pc = 1'b1;
            step();
        end
        i_pc_en = 1'b0; i_rst = 1'b1;
        #1; check("midrst_cyc", {31'b0, o_ibus_cyc}, 32'd0);
        step();
        i_rst = 1'b0;
        do_fetch(0, RST_PC, 32'h1111_2222, 0);
        shift_pc(32'h0000_0440, 0, m);
        do_fetch(0, 32'h0000_0440, 32'h3333_4444, 0);

        // Reset while a word is waiting for the decoder
        shift_pc(32'h0000_0500, 0, m);
        i_ibus_ack = 1'b1; i_ibus_rdt = 32'h5555_6666;
        step();
        i_ibus_ack = 1'b0; i_dec_ready = 1'b1; i_rst = 1'b1;
        #1; check("rstvalid_en", {31'b0, o_dec_en}, 32'd0);
        step();
        i_rst = 1'b0; i_dec_ready = 1'b0;
        #1;
        check("rstvalid_cyc", {31'b0, o_ibus_cyc}, 32'd1);
        check("rstvalid_adr", o_ibus_adr, RST_PC);
        step();
        do_fetch(0, RST_PC, 32'h7777_8888, 1);

        // Zero-wait ack with i_pc_en wiggling while the bus cycle is open
        shift_pc(32'h0000_0300, 0, m);
        i_ibus_ack = 1'b1; i_ibus_rdt = 32'h00a0_0113; i_pc_en = 1'b1; i_pc = 1'b1; i_dec_ready = 1'b0;
        #1;
        check("zw_cyc", {31'b0, o_ibus_cyc}, 32'd1);
        check("zw_adr", o_ibus_adr, 32'h0000_0300);
        step();
        i_ibus_ack = 1'b0; i_pc = 1'b0; i_dec_ready = 1'b1;
        #1;
        check("zw_adr_valid", o_ibus_adr, 32'h0000_0300);
        check("zw_en", {31'b0, o_dec_en}, 32'd1);
        check("zw_rdt", o_dec_rdt, 32'h00a0_0113);
        check("zw_cyc_low", {31'b0, o_ibus_cyc}, 32'd0);
        step();
        i_pc_en = 1'b0; i_dec_ready = 1'b0;
        #1;
        check("zw_adr_waitpc", o_ibus_adr, 32'h0000_0300);
        check("zw_busy", {31'b0, o_busy}, 32'd0);
        step();

        // Bits spread out with idle gaps
        shift_pc(32'h8765_4320, 1, m);
        do_fetch(0, 32'h8765_4320, 32'h0010_0073, 0);

        // Random fetches against the arithmetic model
        for (int n = 0; n < 20; n++) begin
            pc = $urandom;
            w = $urandom;
            shift_pc(pc, int'($urandom_range(2, 0)), m);
            check("model_pc", m, pc);
            do_fetch(int'($urandom_range(3, 0)), m, w, int'($urandom_range(3, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
